// File: rtl/div_scheduler_pkg.sv
// rtl/div_scheduler_pkg.sv - shared types and default sizes for the division scheduler
package div_sched_pkg;

   localparam int DEF_N       = 4;
   localparam int DEF_M       = 2;
   localparam int DEF_TIMEOUT = 4 * DEF_N + 8;

   // Quotient returned on divide-by-zero; truncated to the operand width at use.
   localparam logic [31:0] DBZ_QUOT = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      IDLE,
      LAUNCH,
      WAIT,
      RESP
   } sched_state_e;

endpackage

// File: rtl/div_scheduler_if.sv
// rtl/div_scheduler_if.sv - requester-side request/response bundle of the division scheduler
interface div_scheduler_if #(
   parameter int N = div_sched_pkg::DEF_N,
   parameter int M = div_sched_pkg::DEF_M
);

   logic [M-1:0]   req_valid;
   logic [M*N-1:0] req_dividend;
   logic [M*N-1:0] req_divisor;
   logic [M-1:0]   req_ready;
   logic [M-1:0]   resp_valid;
   logic [N-1:0]   resp_q;
   logic [N-1:0]   resp_r;
   logic           resp_err;

   // Requesters drive operands and consume accepts/results.
   modport master (
      output req_valid, req_dividend, req_divisor,
      input  req_ready, resp_valid, resp_q, resp_r, resp_err
   );

   // The scheduler consumes requests and returns accepts/results.
   modport slave (
      input  req_valid, req_dividend, req_divisor,
      output req_ready, resp_valid, resp_q, resp_r, resp_err
   );

endinterface

// File: rtl/div_scheduler_rr_arbiter.sv
// rtl/div_scheduler_rr_arbiter.sv - combinational round-robin pick starting after the last grant
module rr_arbiter #(
   parameter int M = 2
) (
   input  logic [M-1:0]         req,
   input  logic [$clog2(M)-1:0] last_grant,
   output logic [M-1:0]         grant,
   output logic [$clog2(M)-1:0] grant_idx
);

   localparam int IW = $clog2(M);

   logic found;

   // Scan requesters above the last grant first, then wrap around to the low end.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      for (int i = 0; i < M; i++) begin
         if (!found && (i > int'(last_grant)) && req[i]) begin
            found     = 1'b1;
            grant[i]  = 1'b1;
            grant_idx = IW'(i);
         end
      end
      for (int i = 0; i < M; i++) begin
         if (!found && (i <= int'(last_grant)) && req[i]) begin
            found     = 1'b1;
            grant[i]  = 1'b1;
            grant_idx = IW'(i);
         end
      end
   end

endmodule

// File: rtl/div_scheduler.sv
// rtl/div_scheduler.sv - shares one divider between M requesters with a watchdog per job
module div_scheduler
   import div_sched_pkg::*;
#(
   parameter int N       = DEF_N,
   parameter int M       = DEF_M,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic           clk,
   input  logic           rst,
   div_scheduler_if.slave bus,
   output logic           div_start,
   output logic [N-1:0]   div_dividend,
   output logic [N-1:0]   div_divisor,
   input  logic           div_done,
   input  logic [N-1:0]   div_q,
   input  logic [N-1:0]   div_r
);

   localparam int IW = $clog2(M);
   localparam int WW = $clog2(TIMEOUT + 1);

   sched_state_e  state;
   logic [IW-1:0] last_grant;
   logic [IW-1:0] owner;
   logic [IW-1:0] grant_idx;
   logic [M-1:0]  grant;
   logic [WW-1:0] wd;
   logic [M-1:0]  resp_valid_q;
   logic [N-1:0]  resp_q_q;
   logic [N-1:0]  resp_r_q;
   logic          resp_err_q;
   logic          div_start_q;
   logic [N-1:0]  dividend_q;
   logic [N-1:0]  divisor_q;
   logic [N-1:0]  sel_dividend;
   logic [N-1:0]  sel_divisor;

   rr_arbiter #(.M(M)) u_arb (
      .req        (bus.req_valid),
      .last_grant (last_grant),
      .grant      (grant),
      .grant_idx  (grant_idx)
   );

   // Pick the winning requester's operand slices.
   always_comb begin
      sel_dividend = '0;
      sel_divisor  = '0;
      for (int i = 0; i < M; i++) begin
         if (grant[i]) begin
            sel_dividend = bus.req_dividend[i*N +: N];
            sel_divisor  = bus.req_divisor[i*N +: N];
         end
      end
   end

   // Accept is only offered from IDLE and never while reset is held.
   assign bus.req_ready  = ((state == IDLE) && rst) ? grant : '0;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_q     = resp_q_q;
   assign bus.resp_r     = resp_r_q;
   assign bus.resp_err   = resp_err_q;
   assign div_start      = div_start_q;
   assign div_dividend   = dividend_q;
   assign div_divisor    = divisor_q;

   // Job sequencer: accept, launch, wait for done or watchdog, respond to the owner.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         last_grant   <= IW'(M - 1);
         owner        <= '0;
         wd           <= '0;
         resp_valid_q <= '0;
         resp_q_q     <= '0;
         resp_r_q     <= '0;
         resp_err_q   <= 1'b0;
         div_start_q  <= 1'b0;
         dividend_q   <= '0;
         divisor_q    <= '0;
      end else begin
         div_start_q  <= 1'b0;
         resp_valid_q <= '0;
         case (state)
            IDLE: begin
               if (grant != '0) begin
                  dividend_q <= sel_dividend;
                  divisor_q  <= sel_divisor;
                  owner      <= grant_idx;
                  last_grant <= grant_idx;
                  if (sel_divisor == '0) begin
                     // Divide-by-zero never reaches the divider.
                     resp_q_q     <= N'(DBZ_QUOT);
                     resp_r_q     <= sel_dividend;
                     resp_err_q   <= 1'b1;
                     resp_valid_q <= grant;
                     state        <= RESP;
                  end else begin
                     div_start_q <= 1'b1;
                     state       <= LAUNCH;
                  end
               end
            end
            LAUNCH: begin
               wd    <= '0;
               state <= WAIT;
            end
            WAIT: begin
               if (div_done) begin
                  // A done pulse in the final watchdog cycle still wins.
                  resp_q_q     <= div_q;
                  resp_r_q     <= div_r;
                  resp_err_q   <= 1'b0;
                  resp_valid_q <= M'(1) << owner;
                  state        <= RESP;
               end else if (wd == WW'(TIMEOUT - 1)) begin
                  resp_q_q     <= '0;
                  resp_r_q     <= '0;
                  resp_err_q   <= 1'b1;
                  resp_valid_q <= M'(1) << owner;
                  state        <= RESP;
               end else if (wd != WW'(TIMEOUT)) begin
                  wd <= wd + WW'(1);
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_scheduler.sv
// tb/tb_div_scheduler.sv - scoreboard bench for div_scheduler with a behavioural divider and arbiter model
module tb_div_scheduler;
   import div_sched_pkg::*;

   localparam int N       = 4;
   localparam int M       = 2;
   localparam int TIMEOUT = 4 * N + 8;

   typedef struct {
      int a;
      int b;
   } job_t;

   typedef struct {
      int owner;
      int q;
      int r;
      int err;
      int cyc;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         div_start;
   logic         div_done;
   logic [N-1:0] div_dividend;
   logic [N-1:0] div_divisor;
   logic [N-1:0] div_q;
   logic [N-1:0] div_r;

   div_scheduler_if #(.N(N), .M(M)) bus ();

   div_scheduler #(.N(N), .M(M), .TIMEOUT(TIMEOUT)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .div_start    (div_start),
      .div_dividend (div_dividend),
      .div_divisor  (div_divisor),
      .div_done     (div_done),
      .div_q        (div_q),
      .div_r        (div_r)
   );

   always #5 clk = ~clk;

   int     errors = 0;
   int     checks = 0;
   int     cyc = 0;
   job_t   jobs0[$];
   job_t   jobs1[$];
   exp_t   sb[$];
   int     last_g = M - 1;
   int     busy_until = -1;
   int     start_at = -1;
   int     done_at = -1;
   int     plan_q = 0;
   int     plan_r = 0;
   int     exp_dvd = 0;
   int     exp_dvs = 0;
   int     lat_fixed = 0;
   bit     checking = 1'b0;
   bit [M-1:0] acc = '0;

   always @(posedge clk) cyc = cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Round-robin in plain terms: first pending requester after the last winner, modulo M.
   function automatic int rr_pick(input logic [M-1:0] pend, input int last);
      for (int k = 1; k <= M; k++) begin
         int idx = (last + k) % M;
         if (((pend >> idx) & M'(1)) != '0) return idx;
      end
      return -1;
   endfunction

   task automatic accept(input int g);
      job_t j;
      exp_t e;
      int   lat;
      if (g == 0) j = jobs0[0];
      else        j = jobs1[0];
      last_g = g;
      acc[g] = 1'b1;
      e.owner = g;
      if (j.b == 0) begin
         e.q = 15; e.r = j.a; e.err = 1; e.cyc = cyc + 1;
         start_at = -1;
      end else begin
         lat = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 8));
         start_at = cyc + 1;
         exp_dvd  = j.a;
         exp_dvs  = j.b;
         plan_q   = j.a / j.b;
         plan_r   = j.a % j.b;
         done_at  = cyc + 1 + lat;
         if (lat <= TIMEOUT) begin
            e.q = plan_q; e.r = plan_r; e.err = 0; e.cyc = cyc + 2 + lat;
         end else begin
            e.q = 0; e.r = 0; e.err = 1; e.cyc = cyc + 2 + TIMEOUT;
         end
      end
      busy_until = e.cyc;
      sb.push_back(e);
   endtask

   task automatic monitor_step();
      exp_t e;
      int   g;
      if (cyc == done_at) begin
         div_done = 1'b1;
         div_q    = N'(plan_q);
         div_r    = N'(plan_r);
      end else begin
         div_done = 1'b0;
         div_q    = N'($urandom);
         div_r    = N'($urandom);
      end
      if (cyc > busy_until && bus.req_valid != '0) begin
         g = rr_pick(bus.req_valid, last_g);
         chk("req_ready_grant", int'(bus.req_ready), 1 << g);
         if (int'(bus.req_ready) == (1 << g)) accept(g);
      end else if (bus.req_ready != '0) begin
         chk("req_ready_while_busy", int'(bus.req_ready), 0);
      end
      if (div_start || cyc == start_at) begin
         chk("div_start_timing", int'(div_start), int'(cyc == start_at));
         if (div_start && cyc == start_at) begin
            chk("div_dividend", int'(div_dividend), exp_dvd);
            chk("div_divisor", int'(div_divisor), exp_dvs);
         end
      end
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
         chk("resp_missing_cycle", cyc, sb[0].cyc);
         void'(sb.pop_front());
      end
      if (bus.resp_valid != '0) begin
         if (sb.size() == 0) begin
            chk("resp_unexpected", int'(bus.resp_valid), 0);
         end else begin
            e = sb.pop_front();
            chk("resp_cycle", cyc, e.cyc);
            chk("resp_valid_owner", int'(bus.resp_valid), 1 << e.owner);
            chk("resp_q", int'(bus.resp_q), e.q);
            chk("resp_r", int'(bus.resp_r), e.r);
            chk("resp_err", int'(bus.resp_err), e.err);
         end
      end
   endtask

   // Monitor and divider model, sampling on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (checking) monitor_step();
      end
   end

   // Requester drivers: present the head job until it is accepted.
   initial begin
      bus.req_valid    = '0;
      bus.req_dividend = '0;
      bus.req_divisor  = '0;
      forever begin
         @(posedge clk);
         #1;
         if (acc[0]) begin void'(jobs0.pop_front()); acc[0] = 1'b0; end
         if (acc[1]) begin void'(jobs1.pop_front()); acc[1] = 1'b0; end
         if (jobs0.size() > 0) begin
            bus.req_valid[0]        = 1'b1;
            bus.req_dividend[N-1:0] = N'(jobs0[0].a);
            bus.req_divisor[N-1:0]  = N'(jobs0[0].b);
         end else begin
            bus.req_valid[0] = 1'b0;
         end
         if (jobs1.size() > 0) begin
            bus.req_valid[1]          = 1'b1;
            bus.req_dividend[2*N-1:N] = N'(jobs1[0].a);
            bus.req_divisor[2*N-1:N]  = N'(jobs1[0].b);
         end else begin
            bus.req_valid[1] = 1'b0;
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_req_ready"}, int'(bus.req_ready), 0);
      chk({tag, "_resp_valid"}, int'(bus.resp_valid), 0);
      chk({tag, "_resp_q"}, int'(bus.resp_q), 0);
      chk({tag, "_resp_r"}, int'(bus.resp_r), 0);
      chk({tag, "_resp_err"}, int'(bus.resp_err), 0);
      chk({tag, "_div_start"}, int'(div_start), 0);
      chk({tag, "_div_dividend"}, int'(div_dividend), 0);
      chk({tag, "_div_divisor"}, int'(div_divisor), 0);
   endtask

   task automatic drain(input int extra);
      int n = 0;
      while ((jobs0.size() > 0 || jobs1.size() > 0 || sb.size() > 0 || cyc <= busy_until) && n < 3000) begin
         @(posedge clk);
         n++;
      end
      if (n >= 3000) chk("drain_timeout", n, 0);
      repeat (extra) @(posedge clk);
   endtask

   task automatic push_job(input int r, input int a, input int b);
      job_t j;
      j.a = a;
      j.b = b;
      if (r == 0) jobs0.push_back(j);
      else        jobs1.push_back(j);
   endtask

   initial begin
      int w;
      div_done = 1'b0;
      div_q    = '0;
      div_r    = '0;

      // Reset with a request already pending: nothing may be accepted.
      push_job(0, 13, 3);
      repeat (3) @(posedge clk);
      #2;
      check_reset_outputs("reset");
      rst = 1'b1;
      checking = 1'b1;
      drain(2);

      // Contention between both requesters.
      push_job(0, 9, 2);
      push_job(1, 15, 4);
      push_job(0, 9, 2);
      drain(2);

      // Divide-by-zero short circuit.
      push_job(1, 7, 0);
      drain(2);

      // Watchdog timeout followed by a stale done pulse in IDLE.
      lat_fixed = 30;
      push_job(0, 5, 2);
      drain(12);

      // Done arrives in the last watchdog cycle.
      lat_fixed = TIMEOUT;
      push_job(1, 14, 3);
      drain(2);

      // Randomized traffic with random latency and occasional zero divisors.
      lat_fixed = 0;
      for (int r = 0; r < 12; r++) begin
         for (int i = 0; i < M; i++) begin
            int cnt = int'($urandom_range(0, 2));
            for (int k = 0; k < cnt; k++) begin
               push_job(i, int'($urandom_range(0, 15)),
                        ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 15)));
            end
         end
         repeat ($urandom_range(0, 15)) @(posedge clk);
      end
      drain(2);

      // Reset in the middle of WAIT aborts the job.
      lat_fixed = 20;
      push_job(0, 12, 5);
      w = 0;
      while (sb.size() == 0 && w < 100) begin
         @(posedge clk);
         w++;
      end
      if (w >= 100) chk("accept_timeout", w, 0);
      repeat (4) @(posedge clk);
      #3;
      checking = 1'b0;
      rst = 1'b0;
      #1;
      check_reset_outputs("midjob");
      div_done = 1'b0;
      sb.delete();
      jobs0.delete();
      jobs1.delete();
      acc        = '0;
      done_at    = -1;
      start_at   = -1;
      busy_until = -1;
      last_g     = M - 1;
      lat_fixed  = 0;
      push_job(1, 11, 5);
      push_job(0, 6, 4);
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b1;
      checking = 1'b1;
      drain(6);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/div_scheduler.md
# div_scheduler

Shares one restoring-division unit (datapath plus control) between M requesters. Arbitration is round-robin. The block sequences each job: it latches the operands, pulses the divider start, and waits for completion or a watchdog timeout. It then returns quotient and remainder to the owning requester. Divide-by-zero is short-circuited without touching the divider. The block sits between the requesting blocks and the divider instance.

## Interface
- N, 4: operand width (dividend, divisor, quotient, remainder)
- M, 2: number of requesters (M ≥ 2)
- TIMEOUT, 4*N+8: maximum cycles in WAIT before an error response
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  M  per-requester request; held until accepted
- req_dividend  in  M*N  packed; slice i belongs to requester i
- req_divisor  in  M*N  packed; slice i belongs to requester i
- req_ready  out  M  one-hot accept pulse; operands are sampled this cycle
- resp_valid  out  M  one-hot, 1-cycle result pulse to the owner
- resp_q  out  N  quotient; valid while resp_valid ≠ 0
- resp_r  out  N  remainder; valid while resp_valid ≠ 0
- resp_err  out  1  set with resp_valid on divide-by-zero or timeout
- div_start  out  1  1-cycle start pulse to the divider
- div_dividend  out  N  latched operand; stable from LAUNCH until the next accept
- div_divisor  out  N  latched operand; stable from LAUNCH until the next accept
- div_done  in  1  1-cycle pulse from the divider; results valid this cycle
- div_q  in  N  divider quotient
- div_r  in  N  divider remainder (non-negative, N bits)

## Operation
- States: IDLE, LAUNCH, WAIT, RESP.
- IDLE:
  - If any req_valid is high, pick the winner g by round-robin.
  - Assert req_ready[g]; latch the operands, the owner g, and last_grant ← g.
  - If the divisor is 0, set resp_q = all ones, resp_r = dividend, err = 1, and go to RESP.
  - Otherwise go to LAUNCH.
- LAUNCH: div_start = 1 for one cycle; clear the watchdog; go to WAIT.
- WAIT:
  - On div_done: capture div_q and div_r; err = 0; go to RESP.
  - Otherwise, when the watchdog reaches TIMEOUT-1: set resp_q = 0, resp_r = 0, err = 1; go to RESP.
  - If div_done and the timeout coincide, div_done wins.
- RESP: resp_valid[owner] = 1 for one cycle; go to IDLE.
- Round-robin: search starts at last_grant+1 and wraps modulo M. Reset sets last_grant = M-1, so requester 0 has first priority.
- req_valid is ignored outside IDLE; requests stay pending. There is never more than one job in flight.
- A requester deasserting req_valid before it is accepted withdraws its request; no ordering guarantee is given.
- div_done outside WAIT is ignored. A stale done pulse after a timeout must not produce a second response.
- Watchdog: a counter of ceil(log2(TIMEOUT+1)) bits. It counts only in WAIT and saturates.

## Timing
- Reset (asynchronous, takes effect immediately):
  - state = IDLE.
  - All outputs 0: req_ready, resp_valid, resp_q, resp_r, resp_err, div_start, div_dividend, div_divisor.
  - Watchdog = 0; last_grant = M-1.
- Reset asserted mid-job aborts the job; no response is issued.
- Accept at cycle t → div_start at t+1 → WAIT from t+2.
- div_done at cycle d → resp_valid at d+1.
- Divide-by-zero: accept at t → resp_valid at t+1.
- Timeout: LAUNCH at t → resp_valid at t+1+TIMEOUT.
- Back-to-back throughput: the next accept comes at the earliest 1 cycle after RESP, because IDLE is re-entered.
- All outputs are registered except req_ready, which is decoded from state IDLE and the combinational grant.

## Structure
- Package div_sched_pkg holds:
  - the state enum (IDLE, LAUNCH, WAIT, RESP);
  - the default constants for N, M, and TIMEOUT;
  - the all-ones divide-by-zero quotient constant.
- Sub-module rr_arbiter (parameter M): inputs req[M], last_grant; outputs grant one-hot and grant_idx. It is purely combinational. The pointer register stays in div_scheduler.
- The top module holds the FSM, operand and result registers, owner index, and watchdog counter. Expected size is 150-250 lines.

## Test plan
- Single request: requester 0 sends 13/3 → req_ready[0] pulse; div_start 1 cycle later; after div_done, resp_valid[0] with q=4, r=1, err=0.
- Contention: both req_valid held with 9/2 and 15/4 → order is 0, then 1, then 0 again. Responses are q=4 r=1, then q=3 r=3, each pulse on the correct resp_valid bit only.
- Divide-by-zero: requester 1 sends 7/0 → resp_valid[1] one cycle after accept; q=4'hF, r=7, err=1; div_start never asserted.
- Timeout: the divider model never pulses div_done → resp_valid 1+24 cycles after LAUNCH with err=1 (N=4). A late div_done in IDLE produces no extra response.
- Reset: assert rst low during WAIT → all outputs 0 immediately. After release, requester 0 is granted first and no stale response appears.
- Coincidence: div_done and the timeout in the same cycle → err=0 and the divider result is returned.
